// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every bus signal of the memory-port arbiter: the instruction-fetch
// port, the LSU data port, the shared memory port and the status outputs.
//   slave  : arbiter view (core/memory requests in, grants/responses out)
//   master : environment view (drives core and memory, observes the arbiter)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int WORD_WIDTH = 32
);

  // Instruction-fetch port
  logic                  instr_req_i;
  logic [WORD_WIDTH-1:0] instr_addr_i;
  logic                  instr_gnt_o;
  logic                  instr_rvalid_o;
  logic [WORD_WIDTH-1:0] instr_rdata_o;

  // LSU data port
  logic                  data_req_i;
  logic [WORD_WIDTH-1:0] data_addr_i;
  logic                  data_we_i;
  logic [3:0]            data_be_i;
  logic [WORD_WIDTH-1:0] data_wdata_i;
  logic                  data_gnt_o;
  logic                  data_rvalid_o;
  logic [WORD_WIDTH-1:0] data_rdata_o;

  // Shared memory port
  logic                  mem_req_o;
  logic [WORD_WIDTH-1:0] mem_addr_o;
  logic                  mem_we_o;
  logic [3:0]            mem_be_o;
  logic [WORD_WIDTH-1:0] mem_wdata_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [WORD_WIDTH-1:0] mem_rdata_i;

  // Status
  logic [2:0]            outstanding_o;
  logic                  err_o;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output outstanding_o, err_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  outstanding_o, err_o
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one req/gnt/rvalid memory port between the instruction-fetch and
// LSU ports. The owner is locked while its request waits for mem_gnt_i; each
// grant pushes an owner tag into a small FIFO so that in-order responses are
// routed back to the master that issued them.
// Ports:
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.slave (fetch, LSU, memory and status signals)
// Parameters:
//   WORD_WIDTH      : address/data width
//   MAX_OUTSTANDING : granted-but-unanswered transactions allowed (1..4)
//   DATA_PRIORITY   : 1 = data wins ties, 0 = round-robin tie-break
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int WORD_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int DATA_PRIORITY   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mem_port_arbiter_if.slave      bus
);

  localparam int               PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [2:0]       MAX_CNT  = 3'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_LOCK_I = 2'd1,
    ST_LOCK_D = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  state_e           r_state;
  owner_e           r_last_owner;
  owner_e           r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [2:0]       r_count;
  logic             r_err;

  owner_e                w_owner;
  owner_e                w_pop_tag;
  logic                  w_owner_req;
  logic                  w_full;
  logic                  w_mem_req;
  logic                  w_grant;
  logic                  w_pop;
  logic [WORD_WIDTH-1:0] w_mem_addr;
  logic                  w_mem_we;
  logic [3:0]            w_mem_be;
  logic [WORD_WIDTH-1:0] w_mem_wdata;

  // Circular pointer advance; depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // Owner selection: forced while locked, otherwise arbitrated.
  always_comb begin
    w_owner = OWN_D;
    case (r_state)
      ST_LOCK_I: w_owner = OWN_I;
      ST_LOCK_D: w_owner = OWN_D;
      default: begin
        if (bus.instr_req_i && bus.data_req_i) begin
          if (DATA_PRIORITY != 0) begin
            w_owner = OWN_D;
          end else if (r_last_owner == OWN_D) begin
            w_owner = OWN_I;
          end else begin
            w_owner = OWN_D;
          end
        end else if (bus.instr_req_i) begin
          w_owner = OWN_I;
        end else begin
          w_owner = OWN_D;
        end
      end
    endcase
  end

  // Full is taken from the registered count, so a same-cycle response
  // never opens a slot early.
  assign w_owner_req = (w_owner == OWN_D) ? bus.data_req_i : bus.instr_req_i;
  assign w_full      = (r_count == MAX_CNT);
  assign w_mem_req   = w_owner_req & ~w_full;
  assign w_grant     = w_mem_req & bus.mem_gnt_i;
  assign w_pop       = bus.mem_rvalid_i & (r_count != 3'd0);
  assign w_pop_tag   = r_fifo[r_rd_ptr];

  // Request field mux; everything is zero while no request is presented.
  always_comb begin
    w_mem_addr  = {WORD_WIDTH{1'b0}};
    w_mem_we    = 1'b0;
    w_mem_be    = 4'h0;
    w_mem_wdata = {WORD_WIDTH{1'b0}};
    if (w_mem_req) begin
      if (w_owner == OWN_D) begin
        w_mem_addr  = bus.data_addr_i;
        w_mem_we    = bus.data_we_i;
        w_mem_be    = bus.data_be_i;
        w_mem_wdata = bus.data_wdata_i;
      end else begin
        w_mem_addr  = bus.instr_addr_i;
        w_mem_we    = 1'b0;
        w_mem_be    = 4'hF;
        w_mem_wdata = {WORD_WIDTH{1'b0}};
      end
    end else begin
      w_mem_addr  = {WORD_WIDTH{1'b0}};
      w_mem_we    = 1'b0;
      w_mem_be    = 4'h0;
      w_mem_wdata = {WORD_WIDTH{1'b0}};
    end
  end

  assign bus.mem_req_o      = w_mem_req;
  assign bus.mem_addr_o     = w_mem_addr;
  assign bus.mem_we_o       = w_mem_we;
  assign bus.mem_be_o       = w_mem_be;
  assign bus.mem_wdata_o    = w_mem_wdata;
  assign bus.instr_gnt_o    = w_grant & (w_owner == OWN_I);
  assign bus.data_gnt_o     = w_grant & (w_owner == OWN_D);
  assign bus.instr_rvalid_o = w_pop & (w_pop_tag == OWN_I);
  assign bus.data_rvalid_o  = w_pop & (w_pop_tag == OWN_D);
  assign bus.instr_rdata_o  = bus.mem_rdata_i;
  assign bus.data_rdata_o   = bus.mem_rdata_i;
  assign bus.outstanding_o  = r_count;
  assign bus.err_o          = r_err;

  // Lock FSM: hold the owner while its request waits; a dropped request
  // (protocol violation) releases the lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FREE;
    end else begin
      case (r_state)
        ST_FREE: begin
          if (w_mem_req && !bus.mem_gnt_i) begin
            r_state <= (w_owner == OWN_D) ? ST_LOCK_D : ST_LOCK_I;
          end else begin
            r_state <= ST_FREE;
          end
        end
        ST_LOCK_I: begin
          if (w_grant || !bus.instr_req_i) begin
            r_state <= ST_FREE;
          end else begin
            r_state <= ST_LOCK_I;
          end
        end
        ST_LOCK_D: begin
          if (w_grant || !bus.data_req_i) begin
            r_state <= ST_FREE;
          end else begin
            r_state <= ST_LOCK_D;
          end
        end
        default: r_state <= ST_FREE;
      endcase
    end
  end

  // Last granted master, used by the round-robin tie-break.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_owner <= OWN_D;
    end else if (w_grant) begin
      r_last_owner <= w_owner;
    end else begin
      r_last_owner <= r_last_owner;
    end
  end

  // Owner-tag FIFO and outstanding count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_fifo[i] <= OWN_I;
      end
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= 3'd0;
    end else begin
      if (w_grant) begin
        r_fifo[r_wr_ptr] <= w_owner;
        r_wr_ptr         <= ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      case ({w_grant, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error: a response arrived with nothing outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (bus.mem_rvalid_i && (r_count == 3'd0)) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench: u_dut_p1 (data priority) and u_dut_p0 (round-robin),
// both with MAX_OUTSTANDING = 2, sharing clock and reset.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mem_port_arbiter_if #(.WORD_WIDTH(32)) b1 ();
  mem_port_arbiter_if #(.WORD_WIDTH(32)) b0 ();

  mem_port_arbiter #(.WORD_WIDTH(32), .MAX_OUTSTANDING(2), .DATA_PRIORITY(1)) u_dut_p1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  mem_port_arbiter #(.WORD_WIDTH(32), .MAX_OUTSTANDING(2), .DATA_PRIORITY(0)) u_dut_p0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    b1.instr_req_i = 1'b0; b1.instr_addr_i = 32'h0;
    b1.data_req_i = 1'b0;  b1.data_addr_i = 32'h0; b1.data_we_i = 1'b0;
    b1.data_be_i = 4'h0;   b1.data_wdata_i = 32'h0;
    b1.mem_gnt_i = 1'b0;   b1.mem_rvalid_i = 1'b0; b1.mem_rdata_i = 32'h0;
    b0.instr_req_i = 1'b0; b0.instr_addr_i = 32'h0;
    b0.data_req_i = 1'b0;  b0.data_addr_i = 32'h0; b0.data_we_i = 1'b0;
    b0.data_be_i = 4'h0;   b0.data_wdata_i = 32'h0;
    b0.mem_gnt_i = 1'b0;   b0.mem_rvalid_i = 1'b0; b0.mem_rdata_i = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'd0, b1.mem_req_o}, 32'd0);
    chk("rst_gnts", {30'd0, b1.instr_gnt_o, b1.data_gnt_o}, 32'd0);
    chk("rst_rvalids", {30'd0, b1.instr_rvalid_o, b1.data_rvalid_o}, 32'd0);
    chk("rst_outstanding", {29'd0, b1.outstanding_o}, 32'd0);
    chk("rst_err", {31'd0, b1.err_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Round-robin: both requests held, grants I,D,I,D, responses follow
    b0.instr_req_i = 1'b1; b0.instr_addr_i = 32'h10;
    b0.data_req_i  = 1'b1; b0.data_addr_i  = 32'h20;
    b0.mem_gnt_i   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b0.mem_rvalid_i = (k > 0);
      settle();
      chk($sformatf("rr_instr_gnt_%0d", k), {31'd0, b0.instr_gnt_o}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr_data_gnt_%0d", k), {31'd0, b0.data_gnt_o}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k > 0) begin
        chk($sformatf("rr_instr_rvalid_%0d", k), {31'd0, b0.instr_rvalid_o}, (k % 2 == 1) ? 32'd1 : 32'd0);
      end
      tick();
    end
    b0.instr_req_i = 1'b0; b0.data_req_i = 1'b0; b0.mem_gnt_i = 1'b0;
    b0.mem_rvalid_i = 1'b1;
    settle();
    chk("rr_last_data_rvalid", {31'd0, b0.data_rvalid_o}, 32'd1);
    chk("rr_last_outstanding", {29'd0, b0.outstanding_o}, 32'd1);
    tick();
    b0.mem_rvalid_i = 1'b0;
    settle();
    chk("rr_drained", {29'd0, b0.outstanding_o}, 32'd0);

    // Single fetch with response on the next cycle
    b1.instr_req_i = 1'b1; b1.instr_addr_i = 32'h100; b1.mem_gnt_i = 1'b1;
    settle();
    chk("f_instr_gnt", {31'd0, b1.instr_gnt_o}, 32'd1);
    chk("f_data_gnt", {31'd0, b1.data_gnt_o}, 32'd0);
    chk("f_mem_addr", b1.mem_addr_o, 32'h100);
    chk("f_mem_be", {28'd0, b1.mem_be_o}, 32'hF);
    chk("f_mem_we", {31'd0, b1.mem_we_o}, 32'd0);
    tick();
    b1.instr_req_i = 1'b0; b1.mem_gnt_i = 1'b0;
    b1.mem_rvalid_i = 1'b1; b1.mem_rdata_i = 32'hDEADBEEF;
    settle();
    chk("f_mem_req_idle", {31'd0, b1.mem_req_o}, 32'd0);
    chk("f_mem_addr_idle", b1.mem_addr_o, 32'h0);
    chk("f_instr_rvalid", {31'd0, b1.instr_rvalid_o}, 32'd1);
    chk("f_instr_rdata", b1.instr_rdata_o, 32'hDEADBEEF);
    chk("f_data_rvalid", {31'd0, b1.data_rvalid_o}, 32'd0);
    chk("f_outstanding", {29'd0, b1.outstanding_o}, 32'd1);
    tick();
    b1.mem_rvalid_i = 1'b0;
    settle();
    chk("f_outstanding_end", {29'd0, b1.outstanding_o}, 32'd0);

    // Tie with data priority: data first, then instr; routed responses
    b1.instr_req_i = 1'b1; b1.instr_addr_i = 32'h104;
    b1.data_req_i = 1'b1;  b1.data_addr_i = 32'h200; b1.data_we_i = 1'b1;
    b1.data_be_i = 4'h3;   b1.data_wdata_i = 32'h55;
    b1.mem_gnt_i = 1'b1;
    settle();
    chk("t_data_gnt", {31'd0, b1.data_gnt_o}, 32'd1);
    chk("t_instr_gnt", {31'd0, b1.instr_gnt_o}, 32'd0);
    chk("t_mem_addr_d", b1.mem_addr_o, 32'h200);
    chk("t_mem_we_d", {31'd0, b1.mem_we_o}, 32'd1);
    chk("t_mem_be_d", {28'd0, b1.mem_be_o}, 32'h3);
    chk("t_mem_wdata_d", b1.mem_wdata_o, 32'h55);
    tick();
    b1.data_req_i = 1'b0; b1.data_we_i = 1'b0;
    settle();
    chk("t_outstanding_1", {29'd0, b1.outstanding_o}, 32'd1);
    chk("t_instr_gnt2", {31'd0, b1.instr_gnt_o}, 32'd1);
    chk("t_mem_addr_i", b1.mem_addr_o, 32'h104);
    chk("t_mem_wdata_i", b1.mem_wdata_o, 32'h0);
    tick();
    b1.instr_req_i = 1'b0; b1.mem_gnt_i = 1'b0;
    b1.mem_rvalid_i = 1'b1; b1.mem_rdata_i = 32'hA;
    settle();
    chk("t_outstanding_2", {29'd0, b1.outstanding_o}, 32'd2);
    chk("t_rsp1_data_rvalid", {31'd0, b1.data_rvalid_o}, 32'd1);
    chk("t_rsp1_instr_rvalid", {31'd0, b1.instr_rvalid_o}, 32'd0);
    chk("t_rsp1_data_rdata", b1.data_rdata_o, 32'hA);
    tick();
    b1.mem_rdata_i = 32'hB;
    settle();
    chk("t_outstanding_3", {29'd0, b1.outstanding_o}, 32'd1);
    chk("t_rsp2_instr_rvalid", {31'd0, b1.instr_rvalid_o}, 32'd1);
    chk("t_rsp2_data_rvalid", {31'd0, b1.data_rvalid_o}, 32'd0);
    chk("t_rsp2_instr_rdata", b1.instr_rdata_o, 32'hB);
    tick();
    b1.mem_rvalid_i = 1'b0;
    settle();
    chk("t_outstanding_4", {29'd0, b1.outstanding_o}, 32'd0);

    // Lock: instr waits 3 cycles without grant; data must not steal the port
    b1.instr_req_i = 1'b1; b1.instr_addr_i = 32'h300;
    settle();
    chk("l_mem_req_c0", {31'd0, b1.mem_req_o}, 32'd1);
    chk("l_mem_addr_c0", b1.mem_addr_o, 32'h300);
    tick();
    b1.data_req_i = 1'b1; b1.data_addr_i = 32'h400;
    for (int c = 1; c < 3; c++) begin
      settle();
      chk($sformatf("l_mem_addr_c%0d", c), b1.mem_addr_o, 32'h300);
      chk($sformatf("l_data_gnt_c%0d", c), {31'd0, b1.data_gnt_o}, 32'd0);
      tick();
    end
    b1.mem_gnt_i = 1'b1;
    settle();
    chk("l_instr_gnt", {31'd0, b1.instr_gnt_o}, 32'd1);
    chk("l_data_gnt_hold", {31'd0, b1.data_gnt_o}, 32'd0);
    tick();
    b1.instr_req_i = 1'b0;
    settle();
    chk("l_data_gnt_after", {31'd0, b1.data_gnt_o}, 32'd1);
    chk("l_mem_addr_data", b1.mem_addr_o, 32'h400);
    tick();
    b1.data_req_i = 1'b0; b1.mem_gnt_i = 1'b0;

    // Full: two outstanding, new request blocked even with a same-cycle response
    b1.instr_req_i = 1'b1; b1.instr_addr_i = 32'h500; b1.mem_gnt_i = 1'b1;
    b1.mem_rvalid_i = 1'b1; b1.mem_rdata_i = 32'h11;
    settle();
    chk("x_outstanding_full", {29'd0, b1.outstanding_o}, 32'd2);
    chk("x_mem_req_blocked", {31'd0, b1.mem_req_o}, 32'd0);
    chk("x_instr_gnt_blocked", {31'd0, b1.instr_gnt_o}, 32'd0);
    chk("x_pop_instr", {31'd0, b1.instr_rvalid_o}, 32'd1);
    tick();
    b1.mem_rvalid_i = 1'b0;
    settle();
    chk("x_mem_req_reopen", {31'd0, b1.mem_req_o}, 32'd1);
    chk("x_instr_gnt_reopen", {31'd0, b1.instr_gnt_o}, 32'd1);
    tick();
    b1.instr_req_i = 1'b0; b1.mem_gnt_i = 1'b0;
    b1.mem_rvalid_i = 1'b1; b1.mem_rdata_i = 32'h22;
    settle();
    chk("x_pop_data", {31'd0, b1.data_rvalid_o}, 32'd1);
    chk("x_pop_data_rdata", b1.data_rdata_o, 32'h22);
    tick();
    b1.mem_rdata_i = 32'h33;
    settle();
    chk("x_pop_instr2", {31'd0, b1.instr_rvalid_o}, 32'd1);
    tick();
    b1.mem_rvalid_i = 1'b0;
    settle();
    chk("x_drained", {29'd0, b1.outstanding_o}, 32'd0);

    // Spurious response: sticky error, no routed rvalid
    b1.mem_rvalid_i = 1'b1;
    settle();
    chk("e_no_instr_rvalid", {31'd0, b1.instr_rvalid_o}, 32'd0);
    chk("e_no_data_rvalid", {31'd0, b1.data_rvalid_o}, 32'd0);
    tick();
    b1.mem_rvalid_i = 1'b0;
    settle();
    chk("e_err_set", {31'd0, b1.err_o}, 32'd1);
    chk("e_outstanding", {29'd0, b1.outstanding_o}, 32'd0);
    tick();
    tick();
    chk("e_err_sticky", {31'd0, b1.err_o}, 32'd1);
    chk("e_p0_err_clear", {31'd0, b0.err_o}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("e_err_cleared_by_reset", {31'd0, b1.err_o}, 32'd0);
    #1;
    rst_n = 1'b1;
    tick();

    // Reset mid-transaction, then a late response flags an error
    b1.instr_req_i = 1'b1; b1.instr_addr_i = 32'h600; b1.mem_gnt_i = 1'b1;
    settle();
    chk("m_instr_gnt", {31'd0, b1.instr_gnt_o}, 32'd1);
    tick();
    b1.instr_req_i = 1'b0; b1.mem_gnt_i = 1'b0;
    settle();
    chk("m_outstanding_pre", {29'd0, b1.outstanding_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("m_outstanding_reset", {29'd0, b1.outstanding_o}, 32'd0);
    #1;
    rst_n = 1'b1;
    b1.mem_rvalid_i = 1'b1;
    settle();
    chk("m_late_no_rvalid", {31'd0, b1.instr_rvalid_o}, 32'd0);
    tick();
    b1.mem_rvalid_i = 1'b0;
    settle();
    chk("m_late_err", {31'd0, b1.err_o}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
